// File: rtl/sysram_access_ctrl.sv
// System RAM access sequencer: turns one-shot read/write requests into CS/OE/WE/RDR_EN timing
// and DATA-bus tri-state enables. Optional macro SYSRAM_CTRL_BACK2BACK_EN accepts a new request in DONE.
module sysram_access_ctrl #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 8,
   parameter int RD_WAIT  = 1,
   parameter int WR_PULSE = 1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              req_i,
   input  logic              req_we_i,
   input  logic              req_src_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] ram_data_in_i,
   output logic              busy_o,
   output logic              ack_o,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              ram_cs_o,
   output logic              ram_oe_o,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              alu_bus_en_o,
   output logic              port_bus_en_o,
   output logic              rdr_en_o,
   output logic [2:0]        dbg_state_o
);

   localparam int CNT_MAX = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'((RD_WAIT > 0) ? (RD_WAIT - 1) : 0);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_PULSE - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_RWAIT = 3'd2,
      ST_RCAP  = 3'd3,
      ST_WSTB  = 3'd4,
      ST_WHOLD = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic                src_q, src_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                busy_q, busy_d;
   logic                ack_q, ack_d;
   logic                cs_q, cs_d;
   logic                oe_q, oe_d;
   logic                wstb_q, wstb_d;
   logic                alu_en_q, alu_en_d;
   logic                port_en_q, port_en_d;
   logic                rdr_q, rdr_d;
   logic                bus_d;
   logic                accept;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      we_d      = we_q;
      src_d     = src_q;
      rd_data_d = rd_data_q;
      accept    = 1'b0;

      case (state_q)
         ST_IDLE:  accept = req_i;
         ST_SETUP: begin
            if (we_q) begin
               state_d = ST_WSTB;
               cnt_d   = WR_LOAD;
            end else if (RD_WAIT > 0) begin
               state_d = ST_RWAIT;
               cnt_d   = RD_LOAD;
            end else begin
               state_d = ST_RCAP;
            end
         end
         ST_RWAIT: begin
            if (cnt_q == '0) state_d = ST_RCAP;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_RCAP: begin
            rd_data_d = ram_data_in_i;
            state_d   = ST_DONE;
         end
         ST_WSTB: begin
            if (cnt_q == '0) state_d = ST_WHOLD;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_WHOLD: state_d = ST_DONE;
         ST_DONE: begin
            state_d = ST_IDLE;
`ifdef SYSRAM_CTRL_BACK2BACK_EN
            accept  = req_i;
`else
            accept  = 1'b0;
`endif
         end
         default: state_d = ST_IDLE;
      endcase

      if (accept) begin
         state_d = ST_SETUP;
         addr_d  = req_addr_i;
         we_d    = req_we_i;
         src_d   = req_src_i;
      end

      // Outputs are decoded from the next state so every pin comes straight from a flop.
      busy_d    = (state_d != ST_IDLE);
      ack_d     = (state_d == ST_DONE);
      cs_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
      oe_d      = (state_d == ST_RWAIT) || (state_d == ST_RCAP);
      rdr_d     = (state_d == ST_RCAP);
      wstb_d    = (state_d == ST_WSTB);
      bus_d     = ((state_d == ST_SETUP) && we_d) || (state_d == ST_WSTB) || (state_d == ST_WHOLD);
      alu_en_d  = bus_d && !src_d;
      port_en_d = bus_d && src_d;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         src_q     <= 1'b0;
         rd_data_q <= '0;
         busy_q    <= 1'b0;
         ack_q     <= 1'b0;
         cs_q      <= 1'b0;
         oe_q      <= 1'b0;
         wstb_q    <= 1'b0;
         alu_en_q  <= 1'b0;
         port_en_q <= 1'b0;
         rdr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         src_q     <= src_d;
         rd_data_q <= rd_data_d;
         busy_q    <= busy_d;
         ack_q     <= ack_d;
         cs_q      <= cs_d;
         oe_q      <= oe_d;
         wstb_q    <= wstb_d;
         alu_en_q  <= alu_en_d;
         port_en_q <= port_en_d;
         rdr_q     <= rdr_d;
      end
   end

   assign busy_o        = busy_q;
   assign ack_o         = ack_q;
   assign rd_data_o     = rd_data_q;
   assign ram_cs_o      = cs_q;
   assign ram_oe_o      = oe_q;
   assign ram_we_o      = wstb_q;
   assign ram_addr_o    = addr_q;
   assign alu_bus_en_o  = alu_en_q;
   assign port_bus_en_o = port_en_q;
   assign rdr_en_o      = rdr_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_sysram_access_ctrl.sv
// Bench for sysram_access_ctrl: two instances (default timing, and RD_WAIT=0/WR_PULSE=3),
// a behavioural RAM on the DATA bus, a transaction-level memory model and per-cycle bus invariants.
module tb_sysram_access_ctrl;

   logic       clk;
   logic       rst_n;
   logic       req      [2];
   logic       req_we   [2];
   logic       req_src  [2];
   logic [4:0] req_addr [2];
   logic [7:0] ram_din  [2];
   logic       busy     [2];
   logic       ack      [2];
   logic [7:0] rd_data  [2];
   logic       cs       [2];
   logic       oe       [2];
   logic       we       [2];
   logic [4:0] addr     [2];
   logic       alu_en   [2];
   logic       port_en  [2];
   logic       rdr      [2];
   logic [2:0] dbg      [2];

   logic [7:0] alu_val  [2];
   logic [7:0] port_val [2];
   logic [7:0] phys_mem [2][32];
   logic [7:0] model_mem[2][32];
   bit         valid    [2][32];
   logic [7:0] last_rd  [2];

   logic       prev_busy[2];
   logic       prev_ack [2];
   logic [4:0] prev_addr[2];

   int n_checks = 0;
   int n_errors = 0;

   sysram_access_ctrl #(.ADDR_W(5), .DATA_W(8), .RD_WAIT(1), .WR_PULSE(1)) u_dut_a (
      .clk_i(clk), .rst_n_i(rst_n), .req_i(req[0]), .req_we_i(req_we[0]), .req_src_i(req_src[0]),
      .req_addr_i(req_addr[0]), .ram_data_in_i(ram_din[0]), .busy_o(busy[0]), .ack_o(ack[0]),
      .rd_data_o(rd_data[0]), .ram_cs_o(cs[0]), .ram_oe_o(oe[0]), .ram_we_o(we[0]),
      .ram_addr_o(addr[0]), .alu_bus_en_o(alu_en[0]), .port_bus_en_o(port_en[0]),
      .rdr_en_o(rdr[0]), .dbg_state_o(dbg[0])
   );

   sysram_access_ctrl #(.ADDR_W(5), .DATA_W(8), .RD_WAIT(0), .WR_PULSE(3)) u_dut_b (
      .clk_i(clk), .rst_n_i(rst_n), .req_i(req[1]), .req_we_i(req_we[1]), .req_src_i(req_src[1]),
      .req_addr_i(req_addr[1]), .ram_data_in_i(ram_din[1]), .busy_o(busy[1]), .ack_o(ack[1]),
      .rd_data_o(rd_data[1]), .ram_cs_o(cs[1]), .ram_oe_o(oe[1]), .ram_we_o(we[1]),
      .ram_addr_o(addr[1]), .alu_bus_en_o(alu_en[1]), .port_bus_en_o(port_en[1]),
      .rdr_en_o(rdr[1]), .dbg_state_o(dbg[1])
   );

   function automatic int rd_wait(input int i);
      return (i == 0) ? 1 : 0;
   endfunction

   function automatic int wr_pulse(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared DATA bus: whoever is enabled drives it, RAM writes on a clock edge with WE high.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         ram_din[i] = 8'h00;
         if (oe[i])           ram_din[i] = phys_mem[i][addr[i]];
         else if (alu_en[i])  ram_din[i] = alu_val[i];
         else if (port_en[i]) ram_din[i] = port_val[i];
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++)
         if (we[i] && cs[i]) phys_mem[i][addr[i]] <= alu_en[i] ? alu_val[i] : port_val[i];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         if (n_errors <= 60) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         check("inv_oe_vs_bus", 32'(oe[i] & (alu_en[i] | port_en[i])), 0);
         check("inv_bus_excl", 32'(alu_en[i] & port_en[i]), 0);
         if (we[i]) check("inv_we_cs_onebus", 32'({cs[i], alu_en[i] ^ port_en[i]}), 32'd3);
         if (rdr[i]) check("inv_rdr_oe", 32'(oe[i]), 1);
         if (busy[i] && prev_busy[i] && !prev_ack[i]) check("addr_stable", 32'(addr[i]), 32'(prev_addr[i]));
         prev_busy[i] = busy[i];
         prev_ack[i]  = ack[i];
         prev_addr[i] = addr[i];
      end
   end

   task automatic check_zero_outputs(input int i);
      check("rst_ctrl_bits", 32'({busy[i], ack[i], cs[i], oe[i], we[i], alu_en[i], port_en[i], rdr[i]}), 0);
      check("rst_addr", 32'(addr[i]), 0);
      check("rst_rd_data", 32'(rd_data[i]), 0);
   endtask

   // One complete transaction with window-length, latency and data checks.
   task automatic txn(input int i, input bit w, input bit s, input logic [4:0] a,
                      input logic [7:0] d, input bit spur);
      int lat, exp_lat, n_busy, n_cs, n_we, n_oe, n_rdr, n_alu, n_port, n_badaddr;
      lat = 0; n_busy = 0; n_cs = 0; n_we = 0; n_oe = 0; n_rdr = 0;
      n_alu = 0; n_port = 0; n_badaddr = 0;
      for (int k = 0; k < 20 && busy[i]; k++) tick();
      check("idle_before_req", 32'(busy[i]), 0);
      if (w) begin
         if (s) begin port_val[i] = d;  alu_val[i] = ~d; end
         else   begin alu_val[i]  = d;  port_val[i] = ~d; end
      end else begin
         alu_val[i]  = 8'($urandom);
         port_val[i] = 8'($urandom);
      end
      req[i] = 1'b1; req_we[i] = w; req_src[i] = s; req_addr[i] = a;
      tick();
      req[i] = 1'b0; req_we[i] = 1'($urandom); req_src[i] = 1'($urandom); req_addr[i] = 5'($urandom);
      lat = 1;
      while (lat <= 16) begin
         n_busy += int'(busy[i]);
         n_cs   += int'(cs[i]);
         n_we   += int'(we[i]);
         n_oe   += int'(oe[i]);
         n_rdr  += int'(rdr[i]);
         n_alu  += int'(alu_en[i]);
         n_port += int'(port_en[i]);
         if (cs[i] && addr[i] != a) n_badaddr++;
         if (ack[i]) break;
         if (spur && lat == 1) begin
            req[i] = 1'b1; req_we[i] = 1'($urandom); req_src[i] = 1'($urandom);
            req_addr[i] = 5'($urandom);
         end else if (lat == 2) begin
            req[i] = 1'b0;
         end
         tick();
         lat++;
      end
      req[i] = 1'b0;
      exp_lat = w ? 3 + wr_pulse(i) : 3 + rd_wait(i);
      check(w ? "wr_latency" : "rd_latency", lat, exp_lat);
      check("busy_cycles", n_busy, exp_lat);
      check("cs_cycles", n_cs, exp_lat - 1);
      check("we_cycles", n_we, w ? wr_pulse(i) : 0);
      check("oe_cycles", n_oe, w ? 0 : 1 + rd_wait(i));
      check("rdr_cycles", n_rdr, w ? 0 : 1);
      check("alu_en_cycles", n_alu, (w && !s) ? exp_lat - 1 : 0);
      check("port_en_cycles", n_port, (w && s) ? exp_lat - 1 : 0);
      check("addr_during_cs", n_badaddr, 0);
      if (w) begin
         model_mem[i][a] = d;
         valid[i][a]     = 1'b1;
         check("wr_keeps_rd_data", 32'(rd_data[i]), 32'(last_rd[i]));
      end else if (valid[i][a]) begin
         check("rd_data", 32'(rd_data[i]), 32'(model_mem[i][a]));
         last_rd[i] = model_mem[i][a];
      end
      tick();
      check("ack_single_pulse", 32'(ack[i]), 0);
      check("idle_after_ack", 32'(busy[i]), 0);
   endtask

   // REQ held high across a read: the follow-on access may start only in IDLE, or in DONE when enabled.
   task automatic held_req_read(input logic [4:0] a);
      int lat;
      req[0] = 1'b1; req_we[0] = 1'b0; req_src[0] = 1'b0; req_addr[0] = a;
      tick();
      lat = 1;
      while (lat <= 16 && !ack[0]) begin tick(); lat++; end
      check("held_first_latency", lat, 3 + rd_wait(0));
      check("held_first_rd_data", 32'(rd_data[0]), 32'(model_mem[0][a]));
      check("held_done_cs_off", 32'(cs[0]), 0);
      tick();
`ifdef SYSRAM_CTRL_BACK2BACK_EN
      check("held_b2b_busy", 32'(busy[0]), 1);
      check("held_b2b_cs", 32'(cs[0]), 1);
`else
      check("held_gap_busy", 32'(busy[0]), 0);
      check("held_gap_cs", 32'(cs[0]), 0);
      tick();
      check("held_second_busy", 32'(busy[0]), 1);
      check("held_second_cs", 32'(cs[0]), 1);
`endif
      req[0] = 1'b0;
      lat = 1;
      while (lat <= 16 && !ack[0]) begin tick(); lat++; end
      check("held_second_latency", lat, 3 + rd_wait(0));
      check("held_second_rd_data", 32'(rd_data[0]), 32'(model_mem[0][a]));
      tick();
      check("held_no_third", 32'(busy[0]), 0);
      last_rd[0] = model_mem[0][a];
   endtask

   initial begin
      bit         w, s, spur;
      int         i;
      logic [4:0] a;
      logic [7:0] d;

      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         req[k] = 1'b0; req_we[k] = 1'b0; req_src[k] = 1'b0; req_addr[k] = '0;
         alu_val[k] = '0; port_val[k] = '0; last_rd[k] = '0;
         prev_busy[k] = 1'b0; prev_ack[k] = 1'b0; prev_addr[k] = '0;
         for (int m = 0; m < 32; m++) begin model_mem[k][m] = '0; valid[k][m] = 1'b0; end
      end
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs(0);
      check_zero_outputs(1);
      #2 rst_n = 1'b1;
      tick();

      txn(0, 1'b1, 1'b0, 5'h0A, 8'h5A, 1'b0);
      txn(0, 1'b0, 1'b0, 5'h0A, 8'h00, 1'b0);
      txn(0, 1'b1, 1'b0, 5'h0A, 8'hC3, 1'b0);
      txn(0, 1'b0, 1'b0, 5'h0A, 8'h00, 1'b0);
      txn(1, 1'b1, 1'b1, 5'h0A, 8'hC3, 1'b0);
      txn(1, 1'b0, 1'b0, 5'h0A, 8'h00, 1'b0);
      txn(1, 1'b1, 1'b0, 5'h11, 8'h96, 1'b1);
      txn(1, 1'b0, 1'b0, 5'h11, 8'h00, 1'b1);

      alu_val[0] = 8'h77; port_val[0] = 8'h88;
      req[0] = 1'b1; req_we[0] = 1'b1; req_src[0] = 1'b0; req_addr[0] = 5'h03;
      tick();
      req[0] = 1'b0;
      tick();
      check("rst_test_we_high", 32'(we[0]), 1);
      #2 rst_n = 1'b0;
      #1;
      check_zero_outputs(0);
      check_zero_outputs(1);
      valid[0][3] = 1'b0;
      last_rd[0]  = '0;
      last_rd[1]  = '0;
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         check("rst_no_ack", 32'(ack[0]), 0);
         check("rst_idle", 32'(busy[0]), 0);
      end

      held_req_read(5'h0A);

      for (int n = 0; n < 1000; n++) begin
         i    = (n % 5 == 4) ? 1 : 0;
         a    = 5'($urandom_range(0, 31));
         w    = 1'($urandom_range(0, 1));
         s    = 1'($urandom_range(0, 1));
         d    = 8'($urandom_range(0, 255));
         spur = ($urandom_range(0, 3) == 0);
         if (!valid[i][a]) w = 1'b1;
         txn(i, w, s, a, d, spur);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
